// File: rtl/gt_victim_pkg.sv
// Shared defaults, FSM encoding and address helpers for the victim-buffer controller.
package gt_victim_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_LINE_W = 256;
    localparam int unsigned DEF_OFF_W  = 5;
    localparam int unsigned DEF_CNT_W  = 16;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PROBE    = 3'd1;
    localparam logic [2:0] ST_MEM_REQ  = 3'd2;
    localparam logic [2:0] ST_MEM_WAIT = 3'd3;
    localparam logic [2:0] ST_INSERT   = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;
    localparam logic [2:0] ST_WB       = 3'd6;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        PROBE    = ST_PROBE,
        MEM_REQ  = ST_MEM_REQ,
        MEM_WAIT = ST_MEM_WAIT,
        INSERT   = ST_INSERT,
        RESP     = ST_RESP,
        WB       = ST_WB
    } state_e;

    // Clears the byte-offset bits; callers zero-extend narrower addresses to 64 bits.
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned offW);
        return addr & ~((64'd1 << offW) - 64'd1);
    endfunction

endpackage

// File: rtl/gt_victim_ctrl_if.sv
// Bundle of the L1, victim-buffer and memory signals around gt_victim_ctrl.
interface gt_victim_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned CNT_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_evict_valid;
    logic [ADDR_W-1:0] req_evict_addr;
    logic [LINE_W-1:0] req_evict_line;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_line;
    logic              resp_src;
    logic              vc_probe;
    logic [ADDR_W-1:0] vc_probe_addr;
    logic              vc_hit;
    logic [LINE_W-1:0] vc_line;
    logic              vc_inv;
    logic              vc_ins_valid;
    logic [ADDR_W-1:0] vc_ins_addr;
    logic [LINE_W-1:0] vc_ins_line;
    logic              vc_out_valid;
    logic [ADDR_W-1:0] vc_out_addr;
    logic [LINE_W-1:0] vc_out_line;
    logic              mem_rd_valid;
    logic              mem_rd_ready;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_data_valid;
    logic [LINE_W-1:0] mem_rd_data;
    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [LINE_W-1:0] mem_wr_data;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    // slave: the controller; master: the surrounding L1 / victim buffer / memory.
    modport slave (
        input  req_valid, req_addr, req_evict_valid, req_evict_addr, req_evict_line,
        input  vc_hit, vc_line, vc_out_valid, vc_out_addr, vc_out_line,
        input  mem_rd_ready, mem_rd_data_valid, mem_rd_data, mem_wr_ready,
        output req_ready, resp_valid, resp_line, resp_src,
        output vc_probe, vc_probe_addr, vc_inv, vc_ins_valid, vc_ins_addr, vc_ins_line,
        output mem_rd_valid, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data,
        output hit_cnt, miss_cnt
    );

    modport master (
        output req_valid, req_addr, req_evict_valid, req_evict_addr, req_evict_line,
        output vc_hit, vc_line, vc_out_valid, vc_out_addr, vc_out_line,
        output mem_rd_ready, mem_rd_data_valid, mem_rd_data, mem_wr_ready,
        input  req_ready, resp_valid, resp_line, resp_src,
        input  vc_probe, vc_probe_addr, vc_inv, vc_ins_valid, vc_ins_addr, vc_ins_line,
        input  mem_rd_valid, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/gt_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module gt_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/gt_victim_ctrl.sv
// Sequences one L1 miss at a time through victim-buffer probe, memory fetch,
// victim insert and write-back of any line the victim buffer pushes out.
module gt_victim_ctrl
    import gt_victim_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LINE_W = DEF_LINE_W,
    parameter int unsigned OFF_W  = DEF_OFF_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input logic            CLK,
    input logic            RST,
    gt_victim_ctrl_if.slave bus
);
    state_e            state, stateNext;
    logic [ADDR_W-1:0] reqAddr;
    logic              evValid;
    logic [ADDR_W-1:0] evAddr;
    logic [LINE_W-1:0] evLine;
    logic [LINE_W-1:0] lineBuf;
    logic              srcBuf;
    logic [LINE_W-1:0] respLine;
    logic              respSrc;
    logic              wbPending;
    logic [ADDR_W-1:0] wbAddr;
    logic [LINE_W-1:0] wbLine;
    logic              insOk;
    logic              hitInc, missInc;
    logic [CNT_W-1:0]  hitCount, missCount;

    function automatic logic [ADDR_W-1:0] alignAddr(input logic [ADDR_W-1:0] a);
        return ADDR_W'(line_align(64'(a), OFF_W));
    endfunction

    assign insOk   = evValid && (alignAddr(evAddr) != alignAddr(reqAddr));
    assign hitInc  = (state == PROBE) && bus.vc_hit;
    assign missInc = (state == PROBE) && !bus.vc_hit;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (bus.req_valid) stateNext = PROBE;
            PROBE:    stateNext = bus.vc_hit ? INSERT : MEM_REQ;
            MEM_REQ:  if (bus.mem_rd_ready) stateNext = MEM_WAIT;
            MEM_WAIT: if (bus.mem_rd_data_valid) stateNext = INSERT;
            INSERT:   stateNext = RESP;
            RESP:     stateNext = wbPending ? WB : IDLE;
            WB:       if (bus.mem_wr_ready) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // lineBuf/srcBuf collect the fill; respLine/respSrc only change on entry to RESP
    // so the returned line stays put between responses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            reqAddr   <= '0;
            evValid   <= 1'b0;
            evAddr    <= '0;
            evLine    <= '0;
            lineBuf   <= '0;
            srcBuf    <= 1'b0;
            respLine  <= '0;
            respSrc   <= 1'b0;
            wbPending <= 1'b0;
            wbAddr    <= '0;
            wbLine    <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (bus.req_valid) begin
                    reqAddr <= bus.req_addr;
                    evValid <= bus.req_evict_valid;
                    evAddr  <= bus.req_evict_addr;
                    evLine  <= bus.req_evict_line;
                end
                PROBE: if (bus.vc_hit) begin
                    lineBuf <= bus.vc_line;
                    srcBuf  <= 1'b1;
                end
                MEM_WAIT: if (bus.mem_rd_data_valid) begin
                    lineBuf <= bus.mem_rd_data;
                    srcBuf  <= 1'b0;
                end
                INSERT: begin
                    respLine <= lineBuf;
                    respSrc  <= srcBuf;
                    if (bus.vc_out_valid) begin
                        wbPending <= 1'b1;
                        wbAddr    <= bus.vc_out_addr;
                        wbLine    <= bus.vc_out_line;
                    end
                end
                WB: if (bus.mem_wr_ready) wbPending <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.resp_valid    = (state == RESP);
    assign bus.resp_line     = respLine;
    assign bus.resp_src      = respSrc;
    assign bus.vc_probe      = (state == PROBE);
    assign bus.vc_probe_addr = alignAddr(reqAddr);
    assign bus.vc_inv        = hitInc;
    assign bus.vc_ins_valid  = (state == INSERT) && insOk;
    assign bus.vc_ins_addr   = alignAddr(evAddr);
    assign bus.vc_ins_line   = evLine;
    assign bus.mem_rd_valid  = (state == MEM_REQ);
    assign bus.mem_rd_addr   = alignAddr(reqAddr);
    assign bus.mem_wr_valid  = (state == WB);
    assign bus.mem_wr_addr   = wbAddr;
    assign bus.mem_wr_data   = wbLine;
    assign bus.hit_cnt       = hitCount;
    assign bus.miss_cnt      = missCount;

    gt_sat_counter #(.CNT_W(CNT_W)) uHitCnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (hitInc),
        .count (hitCount)
    );

    gt_sat_counter #(.CNT_W(CNT_W)) uMissCnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (missInc),
        .count (missCount)
    );

endmodule

// File: tb/tb_gt_victim_ctrl.sv
// Scoreboard bench for gt_victim_ctrl: responses and write-backs are queued when
// stimulus is driven and compared when the controller produces them.
module tb_gt_victim_ctrl;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned OFF_W  = 5;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed { logic [LINE_W-1:0] line; logic src; } resp_t;
    typedef struct packed { logic [ADDR_W-1:0] addr; logic [LINE_W-1:0] line; } wb_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    gt_victim_ctrl_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) bus ();

    gt_victim_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic        satInc = 1'b0;
    logic [15:0] satCount;
    gt_sat_counter #(.CNT_W(16)) satDut (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (satInc),
        .count (satCount)
    );

    int          nVectors = 0;
    int          nMiscompares = 0;
    resp_t       expQ[$];
    wb_t         wbQ[$];
    int unsigned insCount = 0;
    int unsigned memRdCount = 0;
    int unsigned memWrCount = 0;

    task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    always begin : monitor
        resp_t e;
        wb_t   w;
        @(negedge CLK);
        #2;
        if (!RST) begin
            if (bus.vc_ins_valid) insCount++;
            if (bus.mem_rd_valid) memRdCount++;
            if (bus.mem_wr_valid) memWrCount++;
            if (bus.resp_valid) begin
                if (expQ.size() == 0) begin
                    checkVal("resp_unexpected", bus.resp_valid, 0);
                end else begin
                    e = expQ.pop_front();
                    checkVal("resp_line", bus.resp_line, e.line);
                    checkVal("resp_src", bus.resp_src, e.src);
                end
            end
            if (bus.mem_wr_valid && bus.mem_wr_ready) begin
                if (wbQ.size() == 0) begin
                    checkVal("wb_unexpected", bus.mem_wr_valid, 0);
                end else begin
                    w = wbQ.pop_front();
                    checkVal("wb_addr", bus.mem_wr_addr, w.addr);
                    checkVal("wb_data", bus.mem_wr_data, w.line);
                end
            end
        end
    end

    task automatic sendReq(input logic [31:0] a, input logic ev, input logic [31:0] ea,
                           input logic [255:0] el);
        int unsigned n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checkVal("req_ready_wait", bus.req_ready, 1);
        bus.req_valid       = 1'b1;
        bus.req_addr        = a;
        bus.req_evict_valid = ev;
        bus.req_evict_addr  = ea;
        bus.req_evict_line  = el;
        @(posedge CLK);
        #1;
        bus.req_valid       = 1'b0;
        bus.req_evict_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic waitResp(input int unsigned maxCyc);
        int unsigned n = 0;
        while (!bus.resp_valid && n < maxCyc) begin
            @(negedge CLK);
            n++;
        end
        checkVal("resp_timeout", bus.resp_valid, 1);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned i0, r0, w0;
        logic [255:0] lineAA, line55, line33, line77, line99, lineCC, lineDD;
        lineAA = {32{8'hAA}};
        line55 = {32{8'h55}};
        line33 = {32{8'h33}};
        line77 = {32{8'h77}};
        line99 = {32{8'h99}};
        lineCC = {32{8'hCC}};
        lineDD = {32{8'hDD}};

        bus.req_valid = 1'b0;         bus.req_addr = '0;
        bus.req_evict_valid = 1'b0;   bus.req_evict_addr = '0;   bus.req_evict_line = '0;
        bus.vc_hit = 1'b0;            bus.vc_line = '0;
        bus.vc_out_valid = 1'b0;      bus.vc_out_addr = '0;      bus.vc_out_line = '0;
        bus.mem_rd_ready = 1'b0;      bus.mem_rd_data_valid = 1'b0; bus.mem_rd_data = '0;
        bus.mem_wr_ready = 1'b0;

        // Reset, then idle
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        checkVal("rst_req_ready", bus.req_ready, 1);
        checkVal("rst_strobes", {bus.vc_probe, bus.vc_inv, bus.vc_ins_valid,
                                 bus.mem_rd_valid, bus.mem_wr_valid, bus.resp_valid}, 0);
        checkVal("rst_hit_cnt", bus.hit_cnt, 0);
        checkVal("rst_miss_cnt", bus.miss_cnt, 0);
        checkVal("rst_resp_line", bus.resp_line, 0);

        // Victim hit, no evict
        bus.vc_hit = 1'b1;
        bus.vc_line = lineAA;
        expQ.push_back(resp_t'{line: lineAA, src: 1'b1});
        r0 = memRdCount;
        w0 = memWrCount;
        sendReq(32'h0000_1234, 1'b0, '0, '0);
        checkVal("hit_probe", bus.vc_probe, 1);
        checkVal("hit_probe_addr", bus.vc_probe_addr, 32'h0000_1220);
        checkVal("hit_inv", bus.vc_inv, 1);
        checkVal("hit_req_ready", bus.req_ready, 0);
        @(negedge CLK);
        bus.vc_hit = 1'b0;
        checkVal("hit_inv_once", bus.vc_inv, 0);
        @(negedge CLK);
        checkVal("hit_latency", bus.resp_valid, 1);
        @(negedge CLK);
        checkVal("hit_resp_once", bus.resp_valid, 0);
        checkVal("hit_cnt1", bus.hit_cnt, 1);
        checkVal("hit_miss_cnt", bus.miss_cnt, 0);
        checkVal("hit_ready_back", bus.req_ready, 1);
        checkVal("hit_no_mem", (memRdCount - r0) + (memWrCount - w0), 0);

        // Miss with memory stall
        expQ.push_back(resp_t'{line: line55, src: 1'b0});
        sendReq(32'h0000_1234, 1'b0, '0, '0);
        checkVal("miss_inv", bus.vc_inv, 0);
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            checkVal("rd_valid_hold", bus.mem_rd_valid, 1);
            checkVal("rd_addr_hold", bus.mem_rd_addr, 32'h0000_1220);
            @(negedge CLK);
        end
        bus.mem_rd_ready = 1'b1;
        checkVal("rd_addr_at_hs", bus.mem_rd_addr, 32'h0000_1220);
        @(posedge CLK);
        #1 bus.mem_rd_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge CLK);
            if (j == 0) checkVal("rd_valid_drop", bus.mem_rd_valid, 0);
        end
        checkVal("resp_line_hold", bus.resp_line, lineAA);
        bus.mem_rd_data_valid = 1'b1;
        bus.mem_rd_data = line55;
        @(posedge CLK);
        #1;
        bus.mem_rd_data_valid = 1'b0;
        bus.mem_rd_data = '0;
        waitResp(5);
        @(negedge CLK);
        checkVal("miss_cnt1", bus.miss_cnt, 1);
        checkVal("miss_hit_cnt", bus.hit_cnt, 1);

        // Miss with evict and displacement
        bus.mem_rd_ready = 1'b1;
        bus.vc_out_valid = 1'b1;
        bus.vc_out_addr = 32'h0000_3000;
        bus.vc_out_line = line99;
        expQ.push_back(resp_t'{line: line33, src: 1'b0});
        wbQ.push_back(wb_t'{addr: 32'h0000_3000, line: line99});
        i0 = insCount;
        sendReq(32'h0000_1234, 1'b1, 32'h0000_2000, line77);
        @(negedge CLK);
        checkVal("ev_rd_valid", bus.mem_rd_valid, 1);
        @(posedge CLK);
        #1 bus.mem_rd_ready = 1'b0;
        @(negedge CLK);
        bus.mem_rd_data_valid = 1'b1;
        bus.mem_rd_data = line33;
        @(posedge CLK);
        #1 bus.mem_rd_data_valid = 1'b0;
        @(negedge CLK);
        checkVal("ins_valid", bus.vc_ins_valid, 1);
        checkVal("ins_addr", bus.vc_ins_addr, 32'h0000_2000);
        checkVal("ins_line", bus.vc_ins_line, line77);
        @(negedge CLK);
        checkVal("ev_resp", bus.resp_valid, 1);
        bus.vc_out_valid = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            checkVal("wb_valid_hold", bus.mem_wr_valid, 1);
            checkVal("wb_addr_hold", bus.mem_wr_addr, 32'h0000_3000);
            checkVal("wb_req_ready", bus.req_ready, 0);
            @(negedge CLK);
        end
        bus.mem_wr_ready = 1'b1;
        @(posedge CLK);
        #1 bus.mem_wr_ready = 1'b0;
        @(negedge CLK);
        checkVal("wb_done_ready", bus.req_ready, 1);
        checkVal("wb_done_valid", bus.mem_wr_valid, 0);
        checkVal("ins_pulses", insCount - i0, 1);
        checkVal("miss_cnt2", bus.miss_cnt, 2);

        // Evict line equals request line: insert suppressed
        bus.vc_hit = 1'b1;
        bus.vc_line = lineCC;
        expQ.push_back(resp_t'{line: lineCC, src: 1'b1});
        i0 = insCount;
        sendReq(32'h0000_1234, 1'b1, 32'h0000_123C, line77);
        @(negedge CLK);
        bus.vc_hit = 1'b0;
        checkVal("same_line_ins", bus.vc_ins_valid, 0);
        @(negedge CLK);
        @(negedge CLK);
        checkVal("same_line_pulses", insCount - i0, 0);
        checkVal("hit_cnt2", bus.hit_cnt, 2);

        // Evict in the neighbouring line: insert without displacement, no write-back
        bus.vc_hit = 1'b1;
        bus.vc_line = lineDD;
        expQ.push_back(resp_t'{line: lineDD, src: 1'b1});
        sendReq(32'h0000_1234, 1'b1, 32'h0000_1200, line77);
        @(negedge CLK);
        bus.vc_hit = 1'b0;
        checkVal("adj_ins", bus.vc_ins_valid, 1);
        checkVal("adj_ins_addr", bus.vc_ins_addr, 32'h0000_1200);
        @(negedge CLK);
        @(negedge CLK);
        checkVal("adj_no_wb", {bus.req_ready, bus.mem_wr_valid}, 2'b10);
        checkVal("hit_cnt3", bus.hit_cnt, 3);

        // Reset while waiting on memory
        bus.mem_rd_ready = 1'b1;
        sendReq(32'h0000_4444, 1'b0, '0, '0);
        @(negedge CLK);
        @(posedge CLK);
        #1 bus.mem_rd_ready = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checkVal("mid_rst_ready", bus.req_ready, 1);
        checkVal("mid_rst_rd_valid", bus.mem_rd_valid, 0);
        checkVal("mid_rst_cnts", {bus.hit_cnt, bus.miss_cnt}, 0);
        checkVal("mid_rst_line", bus.resp_line, 0);
        r0 = memRdCount;
        bus.mem_rd_data_valid = 1'b1;
        bus.mem_rd_data = {32{8'hEE}};
        @(posedge CLK);
        #1 bus.mem_rd_data_valid = 1'b0;
        for (int m = 0; m < 5; m++) begin
            @(negedge CLK);
            checkVal("late_data_resp", bus.resp_valid, 0);
        end
        checkVal("late_data_no_rd", memRdCount - r0, 0);

        // Counter saturation at 0xFFFF
        satInc = 1'b1;
        @(negedge CLK);
        checkVal("sat_first", satCount, 1);
        repeat (65534) @(negedge CLK);
        checkVal("sat_max", satCount, 16'hFFFF);
        @(negedge CLK);
        checkVal("sat_hold", satCount, 16'hFFFF);
        satInc = 1'b0;

        checkVal("resp_drained", expQ.size(), 0);
        checkVal("wb_drained", wbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
